bubble_sort_gen: RTL

//  Parametrised bubble-sort engine. Sorts the first `length` words of an external

---
 rtl/bubble_sort_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bubble_sort_gen.sv
// In-place bubble sort over an external single-port synchronous RAM.
// Stops early after a pass with no swap; reports saturating swap and pass counts.
module bubble_sort_gen #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   output logic              ready,
   input  logic [ADDR_W:0]   length,
   input  logic              descending,
   input  logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] address,
   output logic              wren,
   output logic [DATA_W-1:0] wdata,
   output logic              done,
   output logic [CNT_W-1:0]  swap_count,
   output logic [CNT_W-1:0]  pass_count
);

   typedef enum logic [2:0] {IDLE, RDA, RDB, CMP, WRA, WRB, FIN} state_t;

   localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W:0]     i_q, i_d, limit_q, limit_d;
   logic                desc_q, desc_d, swp_q, swp_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
   logic [CNT_W-1:0]    swap_cnt_q, swap_cnt_d, pass_cnt_q, pass_cnt_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [ADDR_W:0]     ip1, len_v;
   logic                step;

   assign ip1        = i_q + ONE;
   assign swap_count = swap_cnt_q;
   assign pass_count = pass_cnt_q;

   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      limit_d    = limit_q;
      desc_d     = desc_q;
      swp_d      = swp_q;
      a_d        = a_q;
      b_d        = b_q;
      swap_cnt_d = swap_cnt_q;
      pass_cnt_d = pass_cnt_q;
      address    = addr_q;
      wdata      = wdata_q;
      wren       = 1'b0;
      ready      = 1'b0;
      done       = 1'b0;
      step       = 1'b0;
      len_v      = (length > DEPTH_L) ? DEPTH_L : length;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (enable) begin
               desc_d     = descending;
               swap_cnt_d = '0;
               pass_cnt_d = '0;
               limit_d    = len_v - ONE;
               i_d        = '0;
               swp_d      = 1'b0;
               state_d    = (len_v <= ONE) ? FIN : RDA;
            end
         end
         RDA: begin
            address = i_q[ADDR_W-1:0];
            state_d = RDB;
         end
         RDB: begin
            address = ip1[ADDR_W-1:0];
            a_d     = rdata;
            state_d = CMP;
         end
         CMP: begin
            // rdata is mem[i+1] this cycle; compare it directly rather than via b_q
            b_d = rdata;
            if (desc_q ? (a_q < rdata) : (a_q > rdata)) state_d = WRA;
            else                                         step    = 1'b1;
         end
         WRA: begin
            address = i_q[ADDR_W-1:0];
            wdata   = b_q;
            wren    = 1'b1;
            state_d = WRB;
         end
         WRB: begin
            address = ip1[ADDR_W-1:0];
            wdata   = a_q;
            wren    = 1'b1;
            if (swap_cnt_q != '1) swap_cnt_d = swap_cnt_q + 1'b1;
            swp_d   = 1'b1;
            step    = 1'b1;
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (step) begin
         if (ip1 < limit_q) begin
            i_d     = ip1;
            state_d = RDA;
         end else begin
            if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
            if (!swp_d || limit_q == ONE) begin
               state_d = FIN;
            end else begin
               limit_d = limit_q - ONE;
               i_d     = '0;
               swp_d   = 1'b0;
               state_d = RDA;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         i_q        <= '0;
         limit_q    <= '0;
         desc_q     <= 1'b0;
         swp_q      <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         swap_cnt_q <= '0;
         pass_cnt_q <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         limit_q    <= limit_d;
         desc_q     <= desc_d;
         swp_q      <= swp_d;
         a_q        <= a_d;
         b_q        <= b_d;
         swap_cnt_q <= swap_cnt_d;
         pass_cnt_q <= pass_cnt_d;
         addr_q     <= address;
         wdata_q    <= wdata;
      end
   end

endmodule
